// File: rtl/led_panel_pkg.sv
// Shared definitions for LED panel pattern sources: pattern modes, stream FSM states
// and the row index width.
package led_panel_pkg;

    localparam int ROW_W = 3;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_DIAG  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PAUSE  = 2'd1,
        STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/led_pattern_source_if.sv
// Pixel stream between a pattern source (master) and the panel shift/scan driver (slave).
interface led_pattern_source_if #(
    parameter int COLS = 32
);
    import led_panel_pkg::*;

    localparam int COL_W = $clog2(COLS);

    logic             enable_in;
    logic [1:0]       mode_in;
    logic [ROW_W-1:0] rowmax_in;
    logic             pix_ready_in;
    logic             pix_valid_out;
    logic             red_out;
    logic             green_out;
    logic             blue_out;
    logic [COL_W-1:0] col_out;
    logic [ROW_W-1:0] row_out;
    logic             frame_start_out;
    logic             line_last_out;

    modport master (
        input  enable_in, mode_in, rowmax_in, pix_ready_in,
        output pix_valid_out, red_out, green_out, blue_out,
        output col_out, row_out, frame_start_out, line_last_out
    );

    modport slave (
        output enable_in, mode_in, rowmax_in, pix_ready_in,
        input  pix_valid_out, red_out, green_out, blue_out,
        input  col_out, row_out, frame_start_out, line_last_out
    );

endinterface

// File: rtl/led_pattern_colour.sv
// Combinational 3-bit colour index for a pixel position, pattern mode and animation phase.
module led_pattern_colour
    import led_panel_pkg::*;
(
    input  mode_t            mode,
    input  logic [2:0]       col,
    input  logic [ROW_W-1:0] row,
    input  logic [2:0]       phase,
    output logic [2:0]       colour
);

    always_comb begin
        colour = '0;
        case (mode)
            MODE_SOLID: colour = phase;
            MODE_BARS:  colour = col + phase;
            MODE_CHECK: colour = {3{col[0] ^ row[0] ^ phase[0]}};
            MODE_DIAG:  colour = col + row + phase;
            default:    colour = '0;
        endcase
    end

endmodule

// File: rtl/led_pattern_source.sv
// Animated test-pattern pixel source for the LED panel driver, one pixel per accepted
// transfer in raster order; all outputs are registered.
module led_pattern_source
    import led_panel_pkg::*;
#(
    parameter int COLS       = 32,
    parameter int FRAME_HOLD = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    led_pattern_source_if.master pix
);

    localparam int COL_W   = $clog2(COLS);
    localparam int FRAME_W = $clog2(FRAME_HOLD) + 1;

    state_t             state;
    logic [COL_W-1:0]   col_q, col_nx;
    logic [ROW_W-1:0]   row_q, row_nx;
    logic [FRAME_W-1:0] frame_q, frame_nx;
    logic [2:0]         phase_q, phase_nx;
    mode_t              mode_q, mode_nx;
    logic [ROW_W-1:0]   rowmax_q, rowmax_nx;
    logic               valid_q, fs_q, ll_q;
    logic [2:0]         rgb_q;
    logic [2:0]         colour;
    logic               xfer, last_col, last_row, last_frame, frame_end;

    // Next-pixel position and frame parameters; the colour is computed for the
    // pixel that will be presented after this edge.
    always_comb begin
        xfer       = valid_q & pix.pix_ready_in;
        last_col   = (col_q == COL_W'(COLS - 1));
        last_row   = (row_q == rowmax_q);
        last_frame = (frame_q == FRAME_W'(FRAME_HOLD - 1));
        frame_end  = (state == STREAM) && xfer && last_col && last_row;
        col_nx     = col_q;
        row_nx     = row_q;
        frame_nx   = frame_q;
        phase_nx   = phase_q;
        mode_nx    = mode_q;
        rowmax_nx  = rowmax_q;
        if ((state == STREAM) && xfer) begin
            if (last_col) begin
                col_nx = '0;
                if (last_row) begin
                    row_nx = '0;
                    if (last_frame) begin
                        frame_nx = '0;
                        phase_nx = phase_q + 3'd1;
                    end else begin
                        frame_nx = frame_q + FRAME_W'(1);
                    end
                end else begin
                    row_nx = row_q + ROW_W'(1);
                end
            end else begin
                col_nx = col_q + COL_W'(1);
            end
        end
        if (pix.enable_in && ((state == PAUSE) || frame_end)) begin
            mode_nx   = mode_t'(pix.mode_in);
            rowmax_nx = pix.rowmax_in;
        end
    end

    led_pattern_colour u_colour (
        .mode   (mode_nx),
        .col    (3'(col_nx)),
        .row    (row_nx),
        .phase  (phase_nx),
        .colour (colour)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            frame_q  <= '0;
            phase_q  <= '0;
            mode_q   <= MODE_SOLID;
            rowmax_q <= '0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            ll_q     <= 1'b0;
            rgb_q    <= '0;
        end else begin
            case (state)
                IDLE: state <= PAUSE;
                PAUSE: begin
                    if (pix.enable_in) begin
                        state    <= STREAM;
                        mode_q   <= mode_nx;
                        rowmax_q <= rowmax_nx;
                        valid_q  <= 1'b1;
                        fs_q     <= 1'b1;
                        ll_q     <= 1'b0;
                        rgb_q    <= colour;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        col_q    <= col_nx;
                        row_q    <= row_nx;
                        frame_q  <= frame_nx;
                        phase_q  <= phase_nx;
                        mode_q   <= mode_nx;
                        rowmax_q <= rowmax_nx;
                        rgb_q    <= colour;
                        fs_q     <= (col_nx == '0) && (row_nx == '0);
                        ll_q     <= (col_nx == COL_W'(COLS - 1));
                        if (frame_end && !pix.enable_in) begin
                            state   <= PAUSE;
                            valid_q <= 1'b0;
                            fs_q    <= 1'b0;
                            rgb_q   <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pix.pix_valid_out   = valid_q;
    assign pix.red_out         = rgb_q[0];
    assign pix.green_out       = rgb_q[1];
    assign pix.blue_out        = rgb_q[2];
    assign pix.col_out         = col_q;
    assign pix.row_out         = row_q;
    assign pix.frame_start_out = fs_q;
    assign pix.line_last_out   = ll_q;

endmodule

// File: tb/tb_led_pattern_source.sv
// Directed bench for led_pattern_source with COLS=32, FRAME_HOLD=2: raster order, patterns,
// phase animation, backpressure, mid-frame input changes, enable gating and async reset.
module tb_led_pattern_source;
    import led_panel_pkg::*;

    localparam int COLS = 32;
    localparam int HOLD = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   m_frame = 0;
    int   m_phase = 0;

    always #5 clk = ~clk;

    led_pattern_source_if #(.COLS(COLS)) pif ();

    led_pattern_source #(.COLS(COLS), .FRAME_HOLD(HOLD)) u_dut (
        .clk   (clk),
        .reset (reset),
        .pix   (pif.master)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] exp_c(input int md, input int c, input int r, input int ph);
        logic [2:0] c3, r3, p3;
        c3 = 3'(c);
        r3 = 3'(r);
        p3 = 3'(ph);
        case (md)
            0:       return p3;
            1:       return c3 + p3;
            2:       return {3{c3[0] ^ r3[0] ^ p3[0]}};
            default: return c3 + r3 + p3;
        endcase
    endfunction

    function automatic logic [2:0] rgb();
        return {pif.blue_out, pif.green_out, pif.red_out};
    endfunction

    function automatic logic [31:0] obs();
        return {18'b0, pif.pix_valid_out, pif.col_out, pif.row_out,
                pif.frame_start_out, pif.line_last_out, rgb()};
    endfunction

    function automatic logic [31:0] expv(input int c, input int r, input int md);
        return {18'b0, 1'b1, 5'(c), 3'(r), (c == 0 && r == 0), (c == COLS - 1),
                exp_c(md, c, r, m_phase)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_pix(input string tag, input int c, input int r, input int md);
        check($sformatf("%s c%0d r%0d", tag, c, r), obs(), expv(c, r, md));
    endtask

    // Re-checks the same pixel on every stalled cycle, so stability under backpressure is covered.
    task automatic pix(input string tag, input int c, input int r, input int md, input bit bp);
        int stalls = 0;
        bit go = 1'b0;
        while (!go) begin
            check_pix(tag, c, r, md);
            go = !bp || (stalls >= 3) || ($urandom_range(0, 1) == 1);
            pif.pix_ready_in = go;
            @(posedge clk);
            @(negedge clk);
            stalls++;
        end
    endtask

    task automatic run_frame(input string tag, input int md, input int rm, input bit bp,
                             input int chg_c, input int chg_r,
                             input bit n_en, input int n_md, input int n_rm);
        for (int r = 0; r <= rm; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (c == chg_c && r == chg_r) begin
                    pif.enable_in = n_en;
                    pif.mode_in   = 2'(n_md);
                    pif.rowmax_in = 3'(n_rm);
                end
                pix(tag, c, r, md, bp);
            end
        end
        m_frame++;
        if (m_frame == HOLD) begin
            m_frame = 0;
            m_phase = (m_phase + 1) % 8;
        end
    endtask

    initial begin
        pif.enable_in    = 1'b1;
        pif.mode_in      = 2'd0;
        pif.rowmax_in    = 3'd1;
        pif.pix_ready_in = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", obs(), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_valid_low", 32'(pif.pix_valid_out), 32'd0);
        @(negedge clk);

        // Two-row solid frame at phase 0; rowmax change mid-frame applies next frame.
        run_frame("t1", 0, 1, 1'b0, 3, 0, 1'b1, 0, 0);

        for (int f = 1; f <= 16; f++) begin
            if (f == 2)  check("phase1_red", 32'(rgb()), 32'b001);
            if (f == 4)  check("phase2_green", 32'(rgb()), 32'b010);
            if (f == 15) check("phase7_white", 32'(rgb()), 32'b111);
            if (f == 16) check("phase_wrap", 32'(rgb()), 32'b000);
            run_frame("t3", 0, 0, 1'b0, (f == 16) ? 0 : -1, 0, 1'b1, 3, 1);
        end

        run_frame("t2_bp", 3, 1, 1'b1, 0, 0, 1'b1, 1, 3);
        pif.pix_ready_in = 1'b1;
        run_frame("t4_bars", 1, 3, 1'b0, 5, 1, 1'b1, 2, 0);
        run_frame("t4_check", 2, 0, 1'b0, 10, 0, 1'b0, 2, 0);

        for (int i = 0; i < 3; i++) begin
            check("t5_paused_valid", 32'(pif.pix_valid_out), 32'd0);
            @(negedge clk);
        end
        pif.enable_in = 1'b1;
        @(negedge clk);
        run_frame("t5_restart", 2, 0, 1'b0, 0, 0, 1'b1, 3, 3);

        for (int r = 0; r <= 2; r++) begin
            for (int c = 0; c < COLS && !(r == 2 && c == 10); c++) begin
                pix("t6_pre", c, r, 3, 1'b0);
            end
        end
        check_pix("t6_pre", 10, 2, 3);
        #2 reset = 1'b0;
        #1 check("t6_async_clear", obs(), 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        m_frame = 0;
        m_phase = 0;
        @(negedge clk);
        check("t6_pause_valid", 32'(pif.pix_valid_out), 32'd0);
        @(negedge clk);
        run_frame("t6_restart", 3, 3, 1'b0, -1, 0, 1'b1, 3, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_source.md
Name: led_pattern_source

Overview:
- Pixel-stream generator that sits directly upstream of the LED panel shift/scan driver.
- Produces one RGB pixel per accepted transfer in raster order: column fastest, then row, then frame.
- Provides four animated test patterns so the panel driver can be exercised on hardware without a frame buffer.
- Uses a valid/ready handshake; the downstream driver pulls pixels at its own shift rate.

Parameters:
COLS, 32, pixels per row (2..64); column counter width is $clog2(COLS).
FRAME_HOLD, 64, frames per animation step (>=1); frame counter width is $clog2(FRAME_HOLD)+1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset; all state is cleared while low
enable_in  in  1  stream enable; sampled only at frame boundaries
mode_in  in  2  pattern select; sampled at frame start
rowmax_in  in  3  index of last row (rows = rowmax_in+1); sampled at frame start
pix_ready_in  in  1  downstream accepts current pixel
pix_valid_out  out  1  current pixel valid
red_out  out  1  pixel red bit
green_out  out  1  pixel green bit
blue_out  out  1  pixel blue bit
col_out  out  $clog2(COLS)  column of current pixel
row_out  out  3  row of current pixel
frame_start_out  out  1  current pixel is (row 0, col 0)
line_last_out  out  1  current pixel is col COLS-1

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, state IDLE, col/row/frame/phase counters 0, latched mode and rowmax 0.
- Registered outputs only; no combinational path from pix_ready_in to any output.
- Handshake: a transfer occurs on a clk edge where pix_valid_out=1 and pix_ready_in=1.
  - While valid=1 and no transfer occurs, every data output stays stable.
  - Valid never drops without a transfer.
- States: IDLE, STREAM, PAUSE.
  - IDLE -> PAUSE on the first edge after reset release.
  - PAUSE, enable_in=1 -> STREAM. On that edge, latch mode_in and rowmax_in, present pixel (0,0), and set valid=1, frame_start_out=1.
  - PAUSE, enable_in=0 -> stay in PAUSE with valid=0.
  - STREAM, transfer of the last pixel in the frame (col=COLS-1, row=latched rowmax):
    - enable_in=1: stay in STREAM; next pixel is (0,0) with a new latch of mode_in/rowmax_in; valid stays 1 (no bubble).
    - enable_in=0: go to PAUSE with valid=0.
- Counters, advanced on transfer only:
  - col+1; at COLS-1, wrap to 0 and row+1.
  - At row = latched rowmax, wrap row to 0 and frame+1.
  - When frame reaches FRAME_HOLD-1 and wraps, frame -> 0 and phase (3-bit) +1, wrapping 7 -> 0.
- mode_in and rowmax_in changes mid-frame have no effect until the next frame start.
- Colour index c (3 bits), from the next pixel's col/row and phase:
  - mode 0: c = phase (solid fill)
  - mode 1: c = col[2:0] + phase (mod 8) (vertical bars)
  - mode 2: c = {3{col[0]^row[0]^phase[0]}} (checkerboard, white/black)
  - mode 3: c = col[2:0] + row + phase (mod 8) (diagonal)
  - Output mapping: red_out=c[0], green_out=c[1], blue_out=c[2].
- Edge cases:
  - rowmax=0: single-row frames; the row counter stays 0.
  - pix_ready_in held 1 continuously: one pixel per cycle, frames back-to-back.
  - reset asserted mid-frame: immediate clear; after release the stream restarts at frame 0, phase 0, pixel (0,0).

Decomposition:
- Shared package led_panel_pkg holds:
  - mode encodings MODE_SOLID=0, MODE_BARS=1, MODE_CHECK=2, MODE_DIAG=3;
  - state enum IDLE/PAUSE/STREAM;
  - ROW_W=3.
- One natural sub-module: led_pattern_colour (purely combinational), taking mode, col, row and phase and returning the 3-bit colour. It is shared with future pattern sources.
- Counters and the FSM stay in the top block.

Test Plan:
1. Reset release, enable_in=1, ready=1, mode=0, rowmax=1, COLS=32 -> valid rises on the 2nd edge after release; frame_start on pixel (0,0); line_last at col 31; 64 transfers per frame; RGB=000 throughout frame 0.
2. Backpressure: ready toggles pseudo-randomly in mode 3 -> outputs stable while valid&!ready; accepted pixel sequence identical to the ready=1 run.
3. FRAME_HOLD=2, rowmax=0, mode 0 -> phase increments every 2 frames; RGB takes 000, 000, 100, 100, 010 ... (r=c[0]) for frames 0..4; phase wraps 7 -> 0 after 16 frames.
4. Change mode_in 1->2 and rowmax 3->0 at mid-frame (row 1, col 5) -> current frame finishes with 4 rows in bars pattern; the next frame is 1 row of checkerboard.
5. enable_in dropped mid-frame -> frame completes; valid=0 after the last transfer; enable_in re-raised -> next frame starts at (0,0) with frame_start_out=1.
6. reset pulsed low at row 2, col 10 -> all outputs 0 immediately (asynchronous); after release the stream restarts at (0,0) with phase 0.
